// File: rtl/wav_pkg.sv
// wav_pkg: parser states, FOURCC words, error codes and little-endian field helpers
package wav_pkg;
  typedef enum logic [3:0] {
    IDLE, RIFF_ID, RIFF_SIZE, WAVE_ID, CK_ID, CK_SIZE, FMT_BODY, SKIP, STREAM, DONE, ERR
  } state_t;
  localparam logic [31:0] FCC_RIFF = 32'h5249_4646;
  localparam logic [31:0] FCC_WAVE = 32'h5741_5645;
  localparam logic [31:0] FCC_FMT  = 32'h666D_7420;
  localparam logic [31:0] FCC_DATA = 32'h6461_7461;
  localparam logic [2:0] E_NONE        = 3'd0;
  localparam logic [2:0] E_BAD_RIFF    = 3'd1;
  localparam logic [2:0] E_BAD_FMT     = 3'd2;
  localparam logic [2:0] E_NO_FMT      = 3'd3;
  localparam logic [2:0] E_HDR_TIMEOUT = 3'd4;
  function automatic logic [15:0] le16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction
  function automatic logic [31:0] le32(input logic [15:0] a, input logic [15:0] b);
    return {le16(b), le16(a)};
  endfunction
endpackage

// File: rtl/wav_stream_parser.sv
// wav_stream_parser: in-line RIFF/WAVE header parser forwarding byte-swapped PCM words of the data chunk
// Ports: start/in_valid/in_data take the SD word stream; out_valid/out_data/out_last feed the sample FIFO;
// hdr_valid qualifies sample_rate/num_channels/bits_per_sample/data_bytes; busy/done/err/err_code report status.
module wav_stream_parser
  import wav_pkg::*;
#(
  parameter int MAX_HDR_WORDS = 2048,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        hdr_valid,
  output logic [31:0] sample_rate,
  output logic [15:0] num_channels,
  output logic [15:0] bits_per_sample,
  output logic [31:0] data_bytes,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code
);
  localparam int HW = $clog2(MAX_HDR_WORDS + 1);
  state_t state, state_n;
  logic [2:0] code_n;
  logic wsel, fmt_seen, fmt_bad, hdr_st, id_bad, is_fmt, is_data;
  logic [2:0] fmt_idx;
  logic [15:0] id_a, id_b, sz_a, le_w;
  logic [31:0] size_w, magic;
  logic [CNT_W-1:0] cnt, half;
  logic [HW-1:0] hdr_cnt;
  assign le_w = le16(in_data);
  assign size_w = le32(sz_a, in_data);
  // word count of a byte size, rounded up, computed one bit wider so it cannot overflow
  assign half = CNT_W'(({1'b0, CNT_W'(size_w)} + (CNT_W+1)'(1)) >> 1);
  assign magic = state == RIFF_ID ? FCC_RIFF : FCC_WAVE;
  assign id_bad = in_data != (wsel ? magic[15:0] : magic[31:16]);
  assign is_fmt = {id_a, id_b} == FCC_FMT;
  assign is_data = {id_a, id_b} == FCC_DATA;
  assign fmt_bad = (fmt_idx == 3'd0 && le_w != 16'd1) ||
                   (fmt_idx == 3'd1 && le_w != 16'd1 && le_w != 16'd2) ||
                   (fmt_idx == 3'd7 && le_w != 16'd16);
  assign hdr_st = state inside {RIFF_ID, RIFF_SIZE, WAVE_ID, CK_ID, CK_SIZE, FMT_BODY, SKIP};
  assign busy = hdr_st || state == STREAM;
  assign done = state == DONE;
  assign err = state == ERR;
  always_comb begin
    state_n = state;
    code_n = err_code;
    if (start) begin
      state_n = RIFF_ID;
      code_n = E_NONE;
    end else if (in_valid) begin
      case (state)
        RIFF_ID, WAVE_ID: state_n = id_bad ? ERR : !wsel ? state : state == RIFF_ID ? RIFF_SIZE : CK_ID;
        RIFF_SIZE: state_n = wsel ? WAVE_ID : RIFF_SIZE;
        CK_ID: state_n = wsel ? CK_SIZE : CK_ID;
        CK_SIZE: state_n = !wsel ? CK_SIZE :
                           is_fmt ? (size_w < 32'd16 ? ERR : FMT_BODY) :
                           is_data ? (!fmt_seen ? ERR : half == '0 ? DONE : STREAM) :
                           half == '0 ? CK_ID : SKIP;
        // after the 8 fixed words, cnt holds the remaining padded body length
        FMT_BODY: state_n = fmt_bad ? ERR : fmt_idx != 3'd7 ? FMT_BODY : cnt == '0 ? CK_ID : SKIP;
        SKIP: state_n = cnt == CNT_W'(1) ? CK_ID : SKIP;
        STREAM: state_n = cnt == CNT_W'(1) ? DONE : STREAM;
        default: state_n = state;
      endcase
      if (state_n == ERR && state != ERR)
        code_n = state inside {RIFF_ID, WAVE_ID} ? E_BAD_RIFF : (state == CK_SIZE && is_data) ? E_NO_FMT : E_BAD_FMT;
      if (hdr_st && hdr_cnt == HW'(MAX_HDR_WORDS - 1) && !(state_n inside {STREAM, DONE, ERR})) begin
        state_n = ERR;
        code_n = E_HDR_TIMEOUT;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      err_code <= E_NONE;
    end else begin
      state <= state_n;
      err_code <= code_n;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      hdr_valid <= 1'b0;
      sample_rate <= '0;
      num_channels <= '0;
      bits_per_sample <= '0;
      data_bytes <= '0;
      wsel <= 1'b0;
      fmt_seen <= 1'b0;
      fmt_idx <= '0;
      id_a <= '0;
      id_b <= '0;
      sz_a <= '0;
      cnt <= '0;
      hdr_cnt <= '0;
    end else begin
      out_valid <= 1'b0;
      out_last <= 1'b0;
      if (start) begin
        hdr_valid <= 1'b0;
        wsel <= 1'b0;
        fmt_seen <= 1'b0;
        fmt_idx <= '0;
        cnt <= '0;
        hdr_cnt <= '0;
      end else if (in_valid) begin
        if (state inside {RIFF_ID, RIFF_SIZE, WAVE_ID, CK_ID, CK_SIZE})
          wsel <= ~wsel;
        if (hdr_st)
          hdr_cnt <= hdr_cnt + HW'(1);
        case (state)
          CK_ID: if (wsel) id_b <= in_data; else id_a <= in_data;
          CK_SIZE:
            if (!wsel) sz_a <= in_data;
            else begin
              cnt <= is_fmt ? half - CNT_W'(8) : half;
              if (is_data && fmt_seen) begin
                hdr_valid <= 1'b1;
                data_bytes <= size_w;
              end
            end
          FMT_BODY: begin
            fmt_idx <= fmt_idx + 3'd1;
            if (fmt_idx == 3'd1) num_channels <= le_w;
            if (fmt_idx == 3'd2) sample_rate[15:0] <= le_w;
            if (fmt_idx == 3'd3) sample_rate[31:16] <= le_w;
            if (fmt_idx == 3'd7) begin
              bits_per_sample <= le_w;
              fmt_seen <= 1'b1;
            end
          end
          SKIP: cnt <= cnt - CNT_W'(1);
          STREAM: begin
            cnt <= cnt - CNT_W'(1);
            out_valid <= 1'b1;
            out_data <= le_w;
            out_last <= cnt == CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
endmodule
